clk_div_ctrl: RTL

//  Run/stop and ratio controller for the power-of-two clock-divider datapath.
//  - Owns a free-running CNT_W-bit divider counter; exposes all taps (/2,/4,/8,...).
//  - Selects one tap as div_out / div_tick; a valid/ready config port picks it.
//  - Ratio changes land only on a full-period boundary, so div_out never glitches.
//  - Sits between software/config logic and the consumers of the divided clock-enables.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_counter.sv | 58 +++++
 rtl/clk_div_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the power-of-two clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_e;

  // Requests beyond the counter width select the slowest available tap.
  function automatic int unsigned sel_clamp(input int unsigned sel, input int unsigned cnt_w);
    return (sel > cnt_w) ? cnt_w : sel;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Free-running divider counter with tap mux for the selected ratio.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             tick_en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [CNT_W-1:0] div_vec_o,
  output logic             div_out_o,
  output logic             div_tick_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign div_vec_o = cnt_q;
  assign wrap_o    = en_i && (cnt_q == '1);

  // lo_zero accumulates "cnt[i:0] == 0" as the loop walks up the taps.
  always_comb begin
    logic lo_zero;
    lo_zero    = 1'b1;
    div_out_o  = 1'b0;
    div_tick_o = 1'b0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      lo_zero = lo_zero & ~cnt_q[i];
      if (32'(sel_i) == i + 1) begin
        div_out_o  = cnt_q[i];
        div_tick_o = tick_en_i & lo_zero;
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller: config handshake and glitch-free ratio switching.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned RESET_SEL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic [SEL_W-1:0] active_sel,
  output logic [CNT_W-1:0] div_vec,
  output logic             div_out,
  output logic             div_tick
);

  state_e           state_q;
  logic [SEL_W-1:0] active_sel_q;
  logic [SEL_W-1:0] pend_sel_q;
  logic             cfg_done_q;

  logic             accept;
  logic             wrap;
  logic [SEL_W-1:0] sel_c;

  // Holding ready low for the cycle after cfg_done keeps the done pulse from repeating.
  assign cfg_ready = (state_q != PEND) && !cfg_done_q;
  assign accept    = cfg_valid && cfg_ready;
  assign sel_c     = SEL_W'(sel_clamp(32'(cfg_sel), CNT_W));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      active_sel_q <= SEL_W'(RESET_SEL);
      pend_sel_q   <= '0;
      cfg_done_q   <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            active_sel_q <= sel_c;
            cfg_done_q   <= 1'b1;
          end
          if (run) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!run) begin
            state_q <= IDLE;
            if (accept) begin
              active_sel_q <= sel_c;
              cfg_done_q   <= 1'b1;
            end
          end else if (accept) begin
            pend_sel_q <= sel_c;
            state_q    <= PEND;
          end
        end
        PEND: begin
          if (!run || wrap) begin
            active_sel_q <= pend_sel_q;
            cfg_done_q   <= 1'b1;
            state_q      <= run ? RUN : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign active_sel = active_sel_q;
  assign cfg_done   = cfg_done_q;

  clk_div_counter #(
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (!run || (state_q == IDLE)),
    .en_i       (state_q != IDLE),
    .tick_en_i  (state_q != IDLE),
    .sel_i      (active_sel_q),
    .div_vec_o  (div_vec),
    .div_out_o  (div_out),
    .div_tick_o (div_tick),
    .wrap_o     (wrap)
  );

endmodule
